fifo_rd_ctrl: RTL

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_rd_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - async FIFO read-side controller with output register stage
// Synchronizes the write pointer, tracks empty/occupancy, and pops into a one-deep output register.
module fifo_rd_ctrl #(
  parameter int ADDR_SIZE = 4,
  parameter int DATA_SIZE = 8
) (
  input  logic                 r_clk,
  input  logic                 r_rst_n,
  input  logic [ADDR_SIZE:0]   w_ptr_gray,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  output logic [ADDR_SIZE-1:0] r_addr,
  output logic [ADDR_SIZE:0]   r_ptr_gray,
  output logic                 r_empty,
  output logic [ADDR_SIZE:0]   r_count,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } out_state_t;

  out_state_t state_q, state_d;

  logic [ADDR_SIZE:0] wq1, wq2;
  logic [ADDR_SIZE:0] rbin;
  logic [ADDR_SIZE:0] rbin_next;
  logic [ADDR_SIZE:0] rgray_next;
  logic [ADDR_SIZE:0] wbin_sync;
  logic               pop;

  function automatic logic [ADDR_SIZE:0] bin2gray(input logic [ADDR_SIZE:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [ADDR_SIZE:0] gray2bin(input logic [ADDR_SIZE:0] g);
    logic [ADDR_SIZE:0] b;
    b[ADDR_SIZE] = g[ADDR_SIZE];
    for (int i = ADDR_SIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // The write pointer is only ever consumed through this two-flop stage.
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      wq1 <= '0;
      wq2 <= '0;
    end else begin
      wq1 <= w_ptr_gray;
      wq2 <= wq1;
    end
  end

  assign out_valid  = (state_q == ST_HELD);
  assign pop        = !r_empty && (!out_valid || out_ready);
  assign rbin_next  = rbin + {{ADDR_SIZE{1'b0}}, pop};
  assign rgray_next = bin2gray(rbin_next);
  assign wbin_sync  = gray2bin(wq2);
  assign r_addr     = rbin[ADDR_SIZE-1:0];

  // Flags are computed from the post-pop pointer so they agree with this edge's pop.
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      rbin       <= '0;
      r_ptr_gray <= '0;
      r_empty    <= 1'b1;
      r_count    <= '0;
    end else begin
      rbin       <= rbin_next;
      r_ptr_gray <= rgray_next;
      r_empty    <= (rgray_next == wq2);
      r_count    <= wbin_sync - rbin_next;
    end
  end

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      out_data <= '0;
    end else if (pop) begin
      out_data <= mem_rdata;
    end
  end

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (pop) state_d = ST_HELD;
      ST_HELD:  if (out_ready && !pop) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

endmodule
